mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage access controller on the consuming end of the execute-to-memory pipeline register. Each cycle it takes the M-stage control and data (load, store word, store byte, address, store data) and runs the transaction on a req/ack data-memory bus. While a transaction is outstanding it stalls the pipeline. It returns load data, and flags misaligned accesses and bus timeouts, for the memory-to-writeback register.

Parameters:
TIMEOUT, 255, REQ-state cycles without bus_ack before the access is aborted with bus_err (8-bit counter, legal range 1..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_m  input  1  a real instruction occupies the M stage
MemtoRegM  input  1  load word
MemWriteM  input  1  store word
MemWriteSBM  input  1  store byte
ALUOutM  input  32  effective address
WriteDataM  input  32  store data
stall_m  output  1  hold IF..M pipeline registers this cycle
rdata_m  output  32  load data to writeback
rdata_valid  output  1  rdata_m updated this cycle
misalign_m  output  1  word access with ALUOutM[1:0]!=0
bus_err  output  1  access aborted on timeout
bus_req  output  1  bus request, held until ack
bus_we  output  1  1=write, 0=read
bus_addr  output  32  word-aligned address
bus_wdata  output  32  write data
bus_be  output  4  byte enables, bit i = byte lane i (little-endian)
bus_ack  input  1  bus completion, one cycle
bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; timeout counter 0.
  - Reset during REQ drops bus_req immediately; the transaction is abandoned.
- access = valid_m & (MemtoRegM | MemWriteM | MemWriteSBM).
- Priority when several are set: MemWriteSBM > MemWriteM > MemtoRegM.
- misalign_m: combinational = access & word op (MemWriteM or MemtoRegM, not SB) & ALUOutM[1:0]!=0, evaluated only in IDLE.
  - A misaligned access issues no bus cycle and drives stall_m=0; the pipeline advances.
- FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE: if access & !misalign_m, register the bus fields and go to REQ.
    - bus_addr={ALUOutM[31:2],2'b00}.
    - SW: be=4'b1111, wdata=WriteDataM.
    - SB: be=1<<ALUOutM[1:0], wdata={4{WriteDataM[7:0]}}.
    - LW: be=4'b1111, we=0.
  - REQ: bus_req=1 and fields stable. On bus_ack go to DONE and capture bus_rdata for loads.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack, go to DONE with the error flagged.
  - DONE: bus_req=0. If it was a load, rdata_valid=1; rdata_m holds the captured data, or 0 on error. bus_err=1 for this one cycle if aborted. Counter clears. Go to IDLE.
- stall_m = (IDLE & access & !misalign_m) | REQ. It is 0 in DONE, so the M instruction advances at the end of DONE.
- Minimum access with ack in the first REQ cycle: stall_m high 2 cycles, rdata_valid in cycle 3.
- rdata_m is registered and holds its value until the next load completes; stores never change it.
- bus_ack in IDLE or DONE is ignored. bus_ack in the timeout cycle takes priority over the timeout (success).
- Back-to-back accesses: after DONE, IDLE evaluates the new M instruction. There is no dead cycle beyond DONE.
- bus_we/bus_addr/bus_wdata/bus_be hold their last values when bus_req=0.

Test Plan:
- LW 0x0000_1000, bus_ack in first REQ cycle with bus_rdata=0xCAFEBABE -> stall_m high 2 cycles; bus_be=4'hF, bus_we=0; next cycle rdata_valid=1, rdata_m=0xCAFEBABE.
- SB addr 0x0000_2003, WriteDataM=0x1234_56A5, ack after 3 wait cycles -> bus_be=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x0000_2000, stall_m high 5 cycles, rdata_m unchanged.
- SW addr 0x0000_0102 -> misalign_m=1 same cycle, bus_req never asserts, stall_m=0.
- LW with no ack, TIMEOUT=4 -> bus_req high 4 cycles; DONE: bus_err=1, rdata_valid=1, rdata_m=0; back to IDLE.
- rst_n pulled low in second REQ cycle of an SW -> bus_req and stall_m 0 immediately; after release the FSM is IDLE, and a later ack is ignored.
- LW then SW in consecutive instructions, each acked immediately -> two complete 3-cycle sequences with no idle gap; MemWriteSBM and MemWriteM both set -> byte store issued.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: runs M-stage loads/stores on a req/ack data bus.
// Latency: bus access takes IDLE + N REQ cycles + 1 DONE cycle; load data is presented in DONE.
// Backpressure: stall_m holds IF..M while an access launches or is outstanding; misaligned word accesses never stall.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   valid_m, MemtoRegM,        M-stage instruction control: valid, load word,
//   MemWriteM, MemWriteSBM     store word, store byte (SB > SW > LW when several are set)
//   ALUOutM, WriteDataM        effective address and store data
//   stall_m                    hold the pipeline this cycle
//   rdata_m, rdata_valid       registered load data and its update strobe (DONE cycle of a load)
//   misalign_m                 word access to a non-word-aligned address (no bus cycle issued)
//   bus_err                    one-cycle flag in DONE when the access timed out
//   bus_req/we/addr/wdata/be   data-memory request; fields held stable while bus_req is high
//   bus_ack, bus_rdata         one-cycle completion and read data
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_m,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        MemWriteSBM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        stall_m,
    output logic [31:0] rdata_m,
    output logic        rdata_valid,
    output logic        misalign_m,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic access;
    logic word_op;
    logic misalign;
    logic launch;

    assign access   = valid_m & (MemtoRegM | MemWriteM | MemWriteSBM);
    // A byte store wins over word flags, so it is never a word op.
    assign word_op  = ~MemWriteSBM & (MemWriteM | MemtoRegM);
    assign misalign = (state_q == S_IDLE) & access & word_op & (ALUOutM[1:0] != 2'b00);
    assign launch   = (state_q == S_IDLE) & access & ~misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_REQ;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    addr_d  = {ALUOutM[31:2], 2'b00};
                    if (MemWriteSBM) begin
                        we_d    = 1'b1;
                        be_d    = 4'b0001 << ALUOutM[1:0];
                        wdata_d = {4{WriteDataM[7:0]}};
                    end else if (MemWriteM) begin
                        we_d    = 1'b1;
                        be_d    = 4'b1111;
                        wdata_d = WriteDataM;
                    end else begin
                        // Load: write data is left at its previous value.
                        we_d    = 1'b0;
                        be_d    = 4'b1111;
                    end
                end
            end
            S_REQ: begin
                // An ack arriving in the final timeout cycle still counts as success.
                if (bus_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // The IDLE-decoded outputs come straight from M-stage inputs, so they are
    // gated with rst_n to keep every output low while reset is held.
    assign stall_m     = rst_n & (launch | (state_q == S_REQ));
    assign misalign_m  = rst_n & misalign;
    assign bus_req     = (state_q == S_REQ);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_be      = be_q;
    assign rdata_m     = rdata_q;
    assign rdata_valid = (state_q == S_DONE) & ~we_q;
    assign bus_err     = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and
// load responses into queues; a negedge monitor pops and compares them whenever
// the DUT raises bus_req or presents rdata_valid/bus_err.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_m;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic        MemWriteSBM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        stall_m;
    logic [31:0] rdata_m;
    logic        rdata_valid;
    logic        misalign_m;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_m     (valid_m),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .MemWriteSBM (MemWriteSBM),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .stall_m     (stall_m),
        .rdata_m     (rdata_m),
        .rdata_valid (rdata_valid),
        .misalign_m  (misalign_m),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Bus responder controls
    bit          resp_en    = 1'b0;
    bit          force_ack  = 1'b0;
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    logic [31:0] resp_rdata = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: acks after ack_delay REQ cycles; when disabled it drives force_ack.
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            bus_ack = 1'b0;
            if (bus_req) begin
                if (wait_cnt == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = resp_rdata;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            bus_ack  = force_ack;
            wait_cnt = 0;
        end
    end

    // Monitor
    bus_exp_t  cur;
    bit        has_cur  = 1'b0;
    logic      prev_req = 1'b0;
    resp_exp_t r;

    always @(negedge clk) begin
        if (bus_req) begin
            if (!prev_req) begin
                if (bus_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    has_cur = 1'b0;
                    $display("FAIL unexpected_bus_req: got bus_req=1 addr=0x%08h expected no request at %0t", bus_addr, $time);
                end else begin
                    cur     = bus_q.pop_front();
                    has_cur = 1'b1;
                end
            end
            if (has_cur) begin
                chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_be", {28'd0, bus_be}, {28'd0, cur.be});
                if (cur.chk_wd) chk("bus_wdata", bus_wdata, cur.wdata);
            end
        end
        prev_req = bus_req;
        if (rdata_valid || bus_err) begin
            if (resp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata_valid=%0b bus_err=%0b expected none at %0t", rdata_valid, bus_err, $time);
            end else begin
                r = resp_q.pop_front();
                chk("rdata_valid", {31'd0, rdata_valid}, 32'd1);
                chk("rdata_m", rdata_m, r.rdata);
                chk("bus_err", {31'd0, bus_err}, {31'd0, r.err});
            end
        end
    end

    // Issue one M-stage instruction (inputs applied at posedge+1) and follow it
    // until stall_m drops; returns at posedge+1 after the instruction advances.
    task automatic do_op(input string name, input bit lw, input bit sw, input bit sb,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_stall, input int exp_req, input bit exp_mis);
        int n_st;
        int n_rq;
        bit first;
        valid_m     = 1'b1;
        MemtoRegM   = lw;
        MemWriteM   = sw;
        MemWriteSBM = sb;
        ALUOutM     = addr;
        WriteDataM  = wd;
        n_st  = 0;
        n_rq  = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (first) chk({name, "_misalign"}, {31'd0, misalign_m}, {31'd0, exp_mis});
            first = 1'b0;
            if (bus_req) n_rq++;
            if (!stall_m) break;
            n_st++;
            if (n_st > 50) begin
                $display("FAIL %s_stall_bound: stall_m still high after %0d cycles, expected %0d", name, n_st, exp_stall);
                n_chk++;
                n_fail++;
                break;
            end
        end
        chk({name, "_stall_cycles"}, n_st, exp_stall);
        chk({name, "_req_cycles"}, n_rq, exp_req);
        @(posedge clk);
        #1;
        valid_m     = 1'b0;
        MemtoRegM   = 1'b0;
        MemWriteM   = 1'b0;
        MemWriteSBM = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input bit cw);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.be = be; e.chk_wd = cw;
        bus_q.push_back(e);
    endtask

    task automatic push_resp(input logic [31:0] rd, input logic err);
        resp_exp_t e;
        e.rdata = rd; e.err = err;
        resp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        valid_m     = 1'b0;
        MemtoRegM   = 1'b0;
        MemWriteM   = 1'b0;
        MemWriteSBM = 1'b0;
        ALUOutM     = 32'd0;
        WriteDataM  = 32'd0;
        bus_ack     = 1'b0;
        bus_rdata   = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_outputs", {26'd0, stall_m, rdata_valid, misalign_m, bus_err, bus_req, bus_we}, 32'd0);
        chk("rst_rdata_m", rdata_m, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        resp_en = 1'b1;
        @(posedge clk);
        #1;

        // LW, ack in first REQ cycle
        ack_delay = 0; resp_rdata = 32'hCAFEBABE;
        push_bus(1'b0, 32'h0000_1000, 32'd0, 4'hF, 1'b0);
        push_resp(32'hCAFEBABE, 1'b0);
        do_op("lw_fast", 1, 0, 0, 32'h0000_1000, 32'd0, 2, 1, 0);

        // SB to lane 3, ack after 3 wait cycles (lands in last timeout cycle)
        ack_delay = 3; resp_rdata = 32'h5555_5555;
        push_bus(1'b1, 32'h0000_2000, 32'hA5A5A5A5, 4'b1000, 1'b1);
        do_op("sb_wait", 0, 0, 1, 32'h0000_2003, 32'h1234_56A5, 5, 4, 0);
        chk("sb_rdata_hold", rdata_m, 32'hCAFEBABE);

        // Misaligned SW: no bus cycle, no stall
        do_op("sw_misalign", 0, 1, 0, 32'h0000_0102, 32'h7777_7777, 0, 0, 1);

        // LW with no ack: timeout after 4 REQ cycles
        resp_en = 1'b0; force_ack = 1'b0;
        push_bus(1'b0, 32'h0000_3000, 32'd0, 4'hF, 1'b0);
        push_resp(32'd0, 1'b1);
        do_op("lw_timeout", 1, 0, 0, 32'h0000_3000, 32'd0, 5, 4, 0);

        // Reset in second REQ cycle of an SW
        push_bus(1'b1, 32'h0000_5000, 32'h0BAD_F00D, 4'hF, 1'b1);
        valid_m = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h0000_5000; WriteDataM = 32'h0BAD_F00D;
        @(negedge clk); // IDLE launch
        @(negedge clk); // REQ 1
        @(negedge clk); // REQ 2
        chk("rstreq_req_before", {31'd0, bus_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstreq_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstreq_stall", {31'd0, stall_m}, 32'd0);
        @(posedge clk);
        #1;
        valid_m = 1'b0; MemWriteM = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack_idle", {29'd0, bus_req, stall_m, rdata_valid | bus_err}, 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_after", {30'd0, bus_req, rdata_valid | bus_err}, 32'd0);
        @(posedge clk);
        #1;
        resp_en = 1'b1;

        // Back-to-back LW then SW
        ack_delay = 0; resp_rdata = 32'h1122_3344;
        push_bus(1'b0, 32'h0000_6000, 32'd0, 4'hF, 1'b0);
        push_resp(32'h1122_3344, 1'b0);
        do_op("b2b_lw", 1, 0, 0, 32'h0000_6000, 32'd0, 2, 1, 0);
        push_bus(1'b1, 32'h0000_6004, 32'hDEAD_BEEF, 4'hF, 1'b1);
        do_op("b2b_sw", 0, 1, 0, 32'h0000_6004, 32'hDEAD_BEEF, 2, 1, 0);

        // SB and SW both set: byte store wins (odd address is not misaligned)
        push_bus(1'b1, 32'h0000_7000, 32'h7E7E_7E7E, 4'b0010, 1'b1);
        do_op("sb_prio", 0, 1, 1, 32'h0000_7001, 32'h0000_007E, 2, 1, 0);
        chk("final_rdata_hold", rdata_m, 32'h1122_3344);

        repeat (3) @(posedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
